// File: rtl/uart_frame_unpack.sv
// uart_frame_unpack: strips SOF/LEN framing from UART bytes, packs payload into big-endian
// 32-bit words and queues them in a word FIFO; define UART_FRAME_CSUM_EN to expect and check
// a trailing XOR checksum byte.
module uart_frame_unpack #(
  parameter int MAX_WORDS    = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int TIMEOUT_CLKS = 104160
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic [31:0] o_Word,
  output logic        o_Word_Last,
  output logic        o_Word_Valid,
  input  logic        i_Word_Ready,
  output logic        o_Frame_Done,
  output logic        o_Frame_Err,
  output logic [1:0]  o_Err_Code,
  output logic        o_Overflow
);
  localparam int WW = $clog2(MAX_WORDS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_CSUM} state_t;
  state_t        r_state;
  logic [WW-1:0] r_len;
  logic [WW-1:0] r_wcnt;
  logic [1:0]    r_bcnt;
  logic [23:0]   r_pack;
  logic [TW-1:0] r_tmo;
  logic          r_wr_en;
  logic          r_wr_last;
  logic [31:0]   r_wr_data;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]    r_csum;
`endif
  logic [32:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_last;
  logic          w_expire;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  assign w_last   = (r_wcnt + WW'(1)) == r_len;
  assign w_expire = (r_state != S_IDLE) && !i_Rx_DV && (r_tmo == TW'(TIMEOUT_CLKS - 1));
  // Frame parser: tracks framing, packs payload bytes and issues registered word writes and pulses
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_wcnt       <= '0;
      r_bcnt       <= '0;
      r_pack       <= '0;
      r_tmo        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_last    <= 1'b0;
      r_wr_data    <= '0;
`ifdef UART_FRAME_CSUM_EN
      r_csum       <= '0;
`endif
      o_Frame_Done <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Err_Code   <= 2'b00;
    end else begin
      o_Frame_Done <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Err_Code   <= 2'b00;
      r_wr_en      <= 1'b0;
      r_tmo        <= (r_state == S_IDLE || i_Rx_DV) ? '0 : r_tmo + TW'(1);
      if (w_expire) begin
        r_state     <= S_IDLE;
        o_Frame_Err <= 1'b1;
        o_Err_Code  <= 2'b11;
        r_tmo       <= '0;
      end else if (i_Rx_DV) begin
        case (r_state)
          S_IDLE: if (i_Rx_Byte == 8'hA5) r_state <= S_LEN;
          S_LEN: begin
            r_len  <= i_Rx_Byte[WW-1:0];
            r_wcnt <= '0;
            r_bcnt <= '0;
            r_pack <= '0;
`ifdef UART_FRAME_CSUM_EN
            r_csum <= i_Rx_Byte;
`endif
            if (i_Rx_Byte == 8'd0 || i_Rx_Byte > 8'(MAX_WORDS)) begin
              r_state     <= S_IDLE;
              o_Frame_Err <= 1'b1;
              o_Err_Code  <= 2'b01;
            end else begin
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            r_pack <= {r_pack[15:0], i_Rx_Byte};
            r_bcnt <= r_bcnt + 2'd1;
`ifdef UART_FRAME_CSUM_EN
            r_csum <= r_csum ^ i_Rx_Byte;
`endif
            if (r_bcnt == 2'd3) begin
              r_wr_en   <= 1'b1;
              r_wr_data <= {r_pack, i_Rx_Byte};
              r_wr_last <= w_last;
              r_wcnt    <= r_wcnt + WW'(1);
              if (w_last) begin
`ifdef UART_FRAME_CSUM_EN
                r_state <= S_CSUM;
`else
                r_state      <= S_IDLE;
                o_Frame_Done <= 1'b1;
`endif
              end
            end
          end
`ifdef UART_FRAME_CSUM_EN
          S_CSUM: begin
            r_state      <= S_IDLE;
            o_Frame_Done <= i_Rx_Byte == r_csum;
            o_Frame_Err  <= i_Rx_Byte != r_csum;
            o_Err_Code   <= (i_Rx_Byte == r_csum) ? 2'b00 : 2'b10;
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
  assign o_Word_Valid = r_wptr != r_rptr;
  assign w_full       = r_wptr == {~r_rptr[AW], r_rptr[AW-1:0]};
  assign w_pop        = o_Word_Valid & i_Word_Ready;
  assign w_push       = r_wr_en & (~w_full | w_pop);
  assign o_Word       = o_Word_Valid ? r_mem[r_rptr[AW-1:0]][31:0] : '0;
  assign o_Word_Last  = o_Word_Valid & r_mem[r_rptr[AW-1:0]][32];
  // Word FIFO pointers and sticky overflow flag; a full FIFO still accepts a write when popped
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      o_Overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
      if (r_wr_en && w_full && !w_pop) o_Overflow <= 1'b1;
    end
  end
  // Word storage, written with the word and its end-of-frame flag
  always_ff @(posedge i_Clock) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {r_wr_last, r_wr_data};
  end
endmodule
